// File: rtl/lenet_layer_scheduler_pkg.sv
// Shared definitions for the LeNet-5 layer sequencer: FSM encoding,
// layer indices and default sizing.
package lenet_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 20;
  localparam logic [19:0] TIMEOUT_DEF = 20'hF_FFF0;

  localparam logic [1:0] L1_IDX  = 2'd0;
  localparam logic [1:0] L2_IDX  = 2'd1;
  localparam logic [1:0] FC1_IDX = 2'd2;
  localparam logic [1:0] FC_IDX  = 2'd3;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_RUN     = 6'b000010,
    ST_RELEASE = 6'b000100,
    ST_NEXT    = 6'b001000,
    ST_FINISH  = 6'b010000,
    ST_ERR     = 6'b100000
  } sched_state_e;

endpackage

// File: rtl/lenet_layer_scheduler_watchdog.sv
// Saturating per-layer cycle counter with a registered timeout flag that is
// high while the count sits at TIMEOUT_CYCLES-1.
module layer_watchdog_counter
  import lenet_pkg::*;
#(
  parameter int                   CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(TIMEOUT_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] LIMIT   = TIMEOUT_CYCLES - CNT_ONE;

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic                 timeout_r;

  // next count: clear wins, otherwise increment and stick at all-ones
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (en && (cnt_r != '1)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // count and timeout registers; timeout is precomputed from the next count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      timeout_r <= (LIMIT == '0);
    end else begin
      cnt_r     <= cnt_nxt_s;
      timeout_r <= (cnt_nxt_s == LIMIT);
    end
  end

  assign count   = cnt_r;
  assign timeout = timeout_r;

endmodule

// File: rtl/lenet_layer_scheduler.sv
// Runs the LeNet-5 layer engines one at a time through their en/done levels,
// with a per-layer timeout watchdog and per-layer cycle profiling.
module lenet_layer_scheduler
  import lenet_pkg::*;
#(
  parameter int                   NUM_LAYERS     = NUM_LAYERS_DEF,
  parameter int                   CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES = CNT_WIDTH'(TIMEOUT_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [1:0]            cur_layer,
  output logic                  busy,
  output logic                  net_done,
  output logic                  error,
  output logic [1:0]            err_layer,
  output logic                  perf_valid,
  output logic [CNT_WIDTH-1:0]  perf_cycles
);

  localparam logic [1:0]           LAST_IDX = 2'(NUM_LAYERS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [1:0] idx);
    layer_onehot = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (v == '1) ? v : (v + CNT_ONE);
  endfunction

  sched_state_e          st_r, st_s;
  logic                  start_d_r;
  logic [NUM_LAYERS-1:0] layer_en_r, layer_en_s;
  logic [1:0]            cur_layer_r, cur_layer_s;
  logic                  busy_r, busy_s;
  logic                  net_done_r, net_done_s;
  logic                  error_r, error_s;
  logic [1:0]            err_layer_r, err_layer_s;
  logic                  perf_valid_r, perf_valid_s;
  logic [CNT_WIDTH-1:0]  perf_cycles_r, perf_cycles_s;
  logic                  cnt_clr_s, cnt_en_s;
  logic [CNT_WIDTH-1:0]  cnt_s;
  logic                  timeout_s;
  logic                  start_edge_s, done_cur_s, last_s;

  assign start_edge_s = start & ~start_d_r;
  assign done_cur_s   = layer_done[cur_layer_r];
  assign last_s       = (cur_layer_r == LAST_IDX);

  layer_watchdog_counter #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .count   (cnt_s),
    .timeout (timeout_s)
  );

  // next-state and next-output decode; abort overrides every state
  always_comb begin
    st_s          = st_r;
    layer_en_s    = layer_en_r;
    cur_layer_s   = cur_layer_r;
    busy_s        = busy_r;
    net_done_s    = 1'b0;
    error_s       = error_r;
    err_layer_s   = err_layer_r;
    perf_valid_s  = 1'b0;
    perf_cycles_s = perf_cycles_r;
    cnt_clr_s     = 1'b0;
    cnt_en_s      = 1'b0;
    if (abort) begin
      st_s       = ST_IDLE;
      layer_en_s = '0;
      busy_s     = 1'b0;
      cnt_clr_s  = 1'b1;
    end else begin
      case (st_r)
        ST_IDLE, ST_ERR: begin
          if (start_edge_s) begin
            st_s        = ST_RUN;
            cur_layer_s = L1_IDX;
            layer_en_s  = layer_onehot(L1_IDX);
            busy_s      = 1'b1;
            error_s     = 1'b0;
            cnt_clr_s   = 1'b1;
          end else begin
            st_s = st_r;
          end
        end
        ST_RUN: begin
          // done is checked first so it wins a tie with the timeout
          if (done_cur_s) begin
            st_s          = ST_RELEASE;
            layer_en_s    = '0;
            perf_valid_s  = 1'b1;
            perf_cycles_s = sat_inc(cnt_s);
          end else if (timeout_s) begin
            st_s        = ST_ERR;
            layer_en_s  = '0;
            busy_s      = 1'b0;
            error_s     = 1'b1;
            err_layer_s = cur_layer_r;
          end else begin
            cnt_en_s = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!done_cur_s) begin
            cnt_clr_s = 1'b1;
            if (last_s) begin
              st_s       = ST_FINISH;
              net_done_s = 1'b1;
              busy_s     = 1'b0;
            end else begin
              st_s = ST_NEXT;
            end
          end else begin
            st_s = ST_RELEASE;
          end
        end
        ST_NEXT: begin
          st_s        = ST_RUN;
          cur_layer_s = cur_layer_r + 2'd1;
          layer_en_s  = layer_onehot(cur_layer_r + 2'd1);
        end
        ST_FINISH: begin
          st_s = ST_IDLE;
        end
        default: begin
          st_s       = ST_IDLE;
          layer_en_s = '0;
          busy_s     = 1'b0;
          cnt_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r          <= ST_IDLE;
      start_d_r     <= 1'b0;
      layer_en_r    <= '0;
      cur_layer_r   <= 2'd0;
      busy_r        <= 1'b0;
      net_done_r    <= 1'b0;
      error_r       <= 1'b0;
      err_layer_r   <= 2'd0;
      perf_valid_r  <= 1'b0;
      perf_cycles_r <= '0;
    end else begin
      st_r          <= st_s;
      start_d_r     <= start;
      layer_en_r    <= layer_en_s;
      cur_layer_r   <= cur_layer_s;
      busy_r        <= busy_s;
      net_done_r    <= net_done_s;
      error_r       <= error_s;
      err_layer_r   <= err_layer_s;
      perf_valid_r  <= perf_valid_s;
      perf_cycles_r <= perf_cycles_s;
    end
  end

  assign layer_en    = layer_en_r;
  assign cur_layer   = cur_layer_r;
  assign busy        = busy_r;
  assign net_done    = net_done_r;
  assign error       = error_r;
  assign err_layer   = err_layer_r;
  assign perf_valid  = perf_valid_r;
  assign perf_cycles = perf_cycles_r;

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Scoreboard bench: two schedulers (default timeout and a 64-cycle timeout)
// driven by behavioural layer-engine models; a monitor checks observed events.
module tb_lenet_layer_scheduler;

  typedef enum int {K_EN, K_LEN, K_PERF, K_ERR, K_NET} kind_e;
  typedef struct {
    kind_e kind;
    int    val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        start_v [2];
  logic        abort_v [2];
  logic [3:0]  done_w  [2];
  logic [3:0]  en_w    [2];
  logic [1:0]  cur_w   [2];
  logic        busy_w  [2];
  logic        net_w   [2];
  logic        err_w   [2];
  logic [1:0]  errl_w  [2];
  logic        pv_w    [2];
  logic [19:0] pc_w    [2];
  logic [3:0]  stray   [2];
  logic        md      [2][4];
  int          lat     [2][4];
  int          hold    [2][4];
  int          rc      [2][4];
  int          hl      [2][4];

  ev_t q0[$];
  ev_t q1[$];
  int  checks   = 0;
  int  failures = 0;

  lenet_layer_scheduler dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .layer_done(done_w[0]), .layer_en(en_w[0]), .cur_layer(cur_w[0]),
    .busy(busy_w[0]), .net_done(net_w[0]), .error(err_w[0]),
    .err_layer(errl_w[0]), .perf_valid(pv_w[0]), .perf_cycles(pc_w[0])
  );

  lenet_layer_scheduler #(.TIMEOUT_CYCLES(20'd64)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .layer_done(done_w[1]), .layer_en(en_w[1]), .cur_layer(cur_w[1]),
    .busy(busy_w[1]), .net_done(net_w[1]), .error(err_w[1]),
    .err_layer(errl_w[1]), .perf_valid(pv_w[1]), .perf_cycles(pc_w[1])
  );

  // Engine model: done rises so that en is high for exactly lat cycles,
  // then stays high for hold+1 cycles after en drops. lat==0 never finishes.
  for (genvar k = 0; k < 2; k++) begin : g_inst
    assign done_w[k] = {md[k][3], md[k][2], md[k][1], md[k][0]} | stray[k];
    for (genvar i = 0; i < 4; i++) begin : g_layer
      always @(posedge clk) begin
        if (rst_v[k]) begin
          md[k][i] <= 1'b0;
          rc[k][i] <= 0;
          hl[k][i] <= 0;
        end else if (en_w[k][i]) begin
          if (!md[k][i]) begin
            rc[k][i] <= rc[k][i] + 1;
            if (lat[k][i] != 0 && rc[k][i] + 1 == lat[k][i] - 1) begin
              md[k][i] <= 1'b1;
              hl[k][i] <= hold[k][i];
            end
          end
        end else begin
          rc[k][i] <= 0;
          if (md[k][i]) begin
            if (hl[k][i] != 0) hl[k][i] <= hl[k][i] - 1;
            else md[k][i] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int k, input kind_e kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_layer(input int k, input int idx, input int n);
    push(k, K_EN, 1 << idx);
    push(k, K_LEN, n);
    push(k, K_PERF, n);
  endtask

  task automatic push_run(input int k, input int n0, input int n1, input int n2, input int n3);
    push_layer(k, 0, n0);
    push_layer(k, 1, n1);
    push_layer(k, 2, n2);
    push_layer(k, 3, n3);
    push(k, K_NET, 0);
  endtask

  task automatic observe(input int k, input kind_e kind, input int val);
    ev_t e;
    checks++;
    if (qsize(k) == 0) begin
      failures++;
      $display("FAIL sb%0d_unexpected: got %s=%0d expected no event", k, kind.name(), val);
    end else begin
      if (k == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (e.kind != kind || e.val != val) begin
        failures++;
        $display("FAIL sb%0d_event: got %s=%0d expected %s=%0d", k, kind.name(), val,
                 e.kind.name(), e.val);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them
  initial begin
    logic [3:0] en_prev [2];
    int         en_len  [2];
    logic       err_prev[2];
    for (int k = 0; k < 2; k++) begin
      en_prev[k]  = 4'd0;
      en_len[k]   = 0;
      err_prev[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (en_w[k] != en_prev[k]) begin
          if (en_prev[k] != 4'd0) observe(k, K_LEN, en_len[k]);
          if (en_w[k] != 4'd0) begin
            chk("en_onehot", int'($onehot(en_w[k])), 1);
            chk("en_gap", int'(en_prev[k] == 4'd0), 1);
            observe(k, K_EN, int'(en_w[k]));
          end
          en_len[k] = (en_w[k] != 4'd0) ? 1 : 0;
        end else if (en_w[k] != 4'd0) begin
          en_len[k]++;
        end
        if (pv_w[k]) observe(k, K_PERF, int'(pc_w[k]));
        if (err_w[k] && !err_prev[k]) observe(k, K_ERR, int'(errl_w[k]));
        if (net_w[k]) begin
          observe(k, K_NET, 0);
          chk("busy_at_net_done", int'(busy_w[k]), 0);
        end
        en_prev[k]  = en_w[k];
        err_prev[k] = err_w[k];
      end
    end
  end

  task automatic launch(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_en(input int k, input logic [3:0] val, input int budget);
    int b = budget;
    while (en_w[k] !== val && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("wait_en_bound", int'(en_w[k]), int'(val));
  endtask

  task automatic wait_drain(input int k, input int budget);
    int b = budget;
    while ((qsize(k) != 0 || busy_w[k]) && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("drain_bound", qsize(k), 0);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_layer_en", int'(en_w[k]), 0);
    chk("rst_cur_layer", int'(cur_w[k]), 0);
    chk("rst_busy", int'(busy_w[k]), 0);
    chk("rst_net_done", int'(net_w[k]), 0);
    chk("rst_error", int'(err_w[k]), 0);
    chk("rst_err_layer", int'(errl_w[k]), 0);
    chk("rst_perf_valid", int'(pv_w[k]), 0);
    chk("rst_perf_cycles", int'(pc_w[k]), 0);
  endtask

  task automatic set_lat(input int k, input int a, input int b, input int c, input int d);
    lat[k][0] = a;
    lat[k][1] = b;
    lat[k][2] = c;
    lat[k][3] = d;
  endtask

  initial begin
    int dh;
    int g;
    for (int k = 0; k < 2; k++) begin
      rst_v[k]   = 1'b1;
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      stray[k]   = 4'd0;
      for (int i = 0; i < 4; i++) begin
        lat[k][i]  = 10;
        hold[k][i] = 0;
      end
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // full run with distinct per-layer latencies
    set_lat(0, 100, 200, 50, 10);
    push_run(0, 100, 200, 50, 10);
    launch(0);
    wait_drain(0, 600);
    chk("t1_cur_layer_holds", int'(cur_w[0]), 3);

    // layer 1 never finishes: 64-cycle timeout, then relaunch clears error
    set_lat(1, 20, 0, 5, 5);
    push_layer(1, 0, 20);
    push(1, K_EN, 2);
    push(1, K_LEN, 64);
    push(1, K_ERR, 1);
    launch(1);
    wait_drain(1, 300);
    chk("t2_error", int'(err_w[1]), 1);
    chk("t2_err_layer", int'(errl_w[1]), 1);
    chk("t2_busy", int'(busy_w[1]), 0);
    chk("t2_layer_en", int'(en_w[1]), 0);
    lat[1][1] = 5;
    push_run(1, 20, 5, 5, 5);
    @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk);
    chk("t2_error_cleared", int'(err_w[1]), 0);
    chk("t2_relaunch_busy", int'(busy_w[1]), 1);
    chk("t2_relaunch_en", int'(en_w[1]), 1);
    start_v[1] = 1'b0;
    wait_drain(1, 300);

    // abort during layer 2 with start held high
    set_lat(0, 10, 10, 100, 10);
    push_layer(0, 0, 10);
    push_layer(0, 1, 10);
    push(0, K_EN, 4);
    push(0, K_LEN, 21);
    @(negedge clk);
    start_v[0] = 1'b1;
    wait_en(0, 4'b0100, 200);
    repeat (20) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("t3_abort_en", int'(en_w[0]), 0);
    chk("t3_abort_busy", int'(busy_w[0]), 0);
    repeat (5) @(negedge clk);
    chk("t3_no_relaunch_en", int'(en_w[0]), 0);
    chk("t3_no_relaunch_busy", int'(busy_w[0]), 0);
    chk("t3_error_unchanged", int'(err_w[0]), 0);
    chk("t3_queue_empty", qsize(0), 0);
    start_v[0] = 1'b0;
    lat[0][2] = 10;
    push_run(0, 10, 10, 10, 10);
    launch(0);
    wait_drain(0, 300);

    // long done hold on layer 0, plus a stray done on layer 3
    set_lat(0, 30, 10, 10, 10);
    hold[0][0] = 2;
    push_run(0, 30, 10, 10, 10);
    launch(0);
    stray[0] = 4'b1000;
    wait_en(0, 4'b0000, 60);
    stray[0] = 4'd0;
    dh = 0;
    while (done_w[0][0] && dh < 20) begin
      dh++;
      @(negedge clk);
    end
    chk("t4_done_hold_cycles", dh, 3);
    g = 0;
    while (en_w[0] == 4'd0 && g < 20) begin
      g++;
      @(negedge clk);
    end
    chk("t4_release_gap_ge2", int'(g >= 2), 1);
    hold[0][0] = 0;
    wait_drain(0, 200);

    // reset in the middle of layer 1
    set_lat(0, 10, 40, 10, 10);
    push_layer(0, 0, 10);
    push(0, K_EN, 2);
    push(0, K_LEN, 6);
    launch(0);
    wait_en(0, 4'b0010, 100);
    repeat (5) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk_reset(0);
    chk("t6_queue_empty", qsize(0), 0);
    rst_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_queue_b_empty", qsize(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lenet_layer_scheduler.md
Name: lenet_layer_scheduler

Overview:
Top-level sequencer for the LeNet-5 accelerator. It runs the layer engines (front conv+pool layer, second conv+pool layer, FC layers) strictly in order, one at a time, using each engine's level enable/done handshake. It guards each layer with a timeout watchdog and reports per-layer cycle counts for profiling. It sits between the host start/status interface and the layer wrappers' en/done pins.

Parameters:
NUM_LAYERS, 4, number of sequenced layer engines; index 0 runs first.
CNT_WIDTH, 20, width of the cycle counter and timeout compare.
TIMEOUT_CYCLES, 20'hF_FFF0, maximum enable-high cycles per layer before error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  level; rising edge in IDLE launches a full network run
abort  in  1  level; drops all enables and returns to IDLE
layer_done  in  NUM_LAYERS  per-layer done level; high while that engine sits in its DONE state
layer_en  out  NUM_LAYERS  one-hot-or-zero enable; held high while the layer runs
cur_layer  out  2  index of the active or last-run layer
busy  out  1  high from launch until FINISH or ERROR
net_done  out  1  one-cycle pulse when the last layer completes
error  out  1  sticky timeout flag; cleared by rst or by a new start edge
err_layer  out  2  layer index that timed out
perf_valid  out  1  one-cycle pulse when perf_cycles is updated
perf_cycles  out  CNT_WIDTH  enable-high cycle count of the layer just finished

Behaviour:
- Reset: st=IDLE; layer_en=0, cur_layer=0, busy=0, net_done=0, error=0, err_layer=0, perf_valid=0, perf_cycles=0, cycle counter=0, start_d=0.
- States are one-hot 6'b: IDLE, RUN, RELEASE, NEXT, FINISH, ERR.
- IDLE: on start & ~start_d, go to RUN with cur_layer=0, clear error, set busy=1. A held start does not retrigger.
- RUN: layer_en[cur_layer]=1 (registered) and the counter increments each cycle.
  - layer_done[cur_layer]=1 → clear layer_en, set perf_cycles=counter+1 and perf_valid=1, go to RELEASE.
  - counter==TIMEOUT_CYCLES-1 with done still low → clear layer_en, set error=1 and err_layer=cur_layer, go to ERR.
  - If done and the timeout fall on the same cycle, done wins.
- RELEASE: stay until layer_done[cur_layer]==0. Engine done falls one cycle after en drops, so this state lasts at least 1 cycle. Then clear the counter: go to FINISH if cur_layer==NUM_LAYERS-1, else go to NEXT.
- NEXT: cur_layer+1, then RUN. This gives a guaranteed cycle with all enables low between layers, so the engine returns to IDLE before the next layer starts.
- FINISH: net_done=1 for exactly one cycle, busy=0, then IDLE. cur_layer holds its last value.
- ERR: busy=0; error and err_layer hold. Leave only on a start rising edge (clears error and relaunches at layer 0) or on rst.
- abort=1 in any state: next cycle layer_en=0, busy=0, counter=0, st=IDLE. error is unchanged and net_done is not pulsed. abort has priority over all other transitions.
- layer_done bits for non-current layers are ignored.
- layer_en is never multi-hot.
- The counter saturates at all-ones; it does not wrap.
- Reset mid-run behaves as full reset; the enable drops on the next edge.

Decomposition:
- Shared package lenet_pkg holds:
  - state encodings (IDLE/RUN/RELEASE/NEXT/FINISH/ERR)
  - layer index constants (L1_IDX=0 … FC_IDX=3)
  - NUM_LAYERS and CNT_WIDTH defaults
- One sub-module: layer_watchdog_counter (clear, enable, saturating count, timeout compare output), reusable by other layer controllers.

Test Plan:
1. start 0→1; each layer model asserts done 100/200/50/10 cycles after en rises. Required: en sequence 0001,0010,0100,1000; perf_cycles 100,200,50,10 with a perf_valid pulse each; ≥1 all-zero enable cycle between layers; single net_done; busy falls with net_done.
2. TIMEOUT_CYCLES=64 and layer 1 never asserts done. Required: layer_en=0010 for exactly 64 cycles, then 0000; error=1, err_layer=1, busy=0, no net_done. A new start edge clears error and relaunches layer 0.
3. abort raised during layer 2 RUN. Required: next cycle layer_en=0, busy=0, st=IDLE; start still high does not relaunch until it toggles low→high.
4. Layer 0 done held high for 3 cycles after en drops. Required: the scheduler stays in RELEASE until done=0, and layer_en[1] rises no earlier than 2 cycles after done falls.
5. Stray layer_done[3]=1 while layer 0 runs. Required: ignored; layer 0 completes normally.
6. rst asserted mid-layer 1. Required: all outputs return to reset values on the next edge; error=0.
